game_flow_controller: RTL

GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

---
 rtl/game_flow_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/game_flow_controller.sv
// game_flow_controller
// Top-level game sequencer: title screen, per-level play, result pauses,
// game over and victory. Drives the shared level reset and overlay code.
// Optional feature macro: GAME_FLOW_LIVES_EN (lives tracking). When it is
// undefined, lives stay at START_LIVES and a death restarts from level 0.
module game_flow_controller #(
   parameter int NUM_LEVELS   = 3,
   parameter int START_LIVES  = 3,
   parameter int PAUSE_CYCLES = 25000000
) (
   input  logic       vga_clock,
   input  logic       reset,
   input  logic       start_button,
   input  logic       level_win,
   input  logic       level_lose,
   output logic [2:0] level_sel,
   output logic       level_reset_n,
   output logic [2:0] lives,
   output logic [2:0] screen
);

   localparam logic [2:0] ST_TITLE     = 3'd0;
   localparam logic [2:0] ST_ARM       = 3'd1;
   localparam logic [2:0] ST_PLAY      = 3'd2;
   localparam logic [2:0] ST_CLEAR     = 3'd3;
   localparam logic [2:0] ST_DIED      = 3'd4;
   localparam logic [2:0] ST_GAME_OVER = 3'd5;
   localparam logic [2:0] ST_VICTORY   = 3'd6;

   // Pause counter needs at least one bit even for a single-cycle pause.
   localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
   localparam logic [PW-1:0] PAUSE_LOAD = PW'(PAUSE_CYCLES - 1);
   localparam logic [2:0]    LAST_LEVEL = 3'(NUM_LEVELS - 1);
   localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);

   logic [2:0]    state_reg, state_next;
   logic [2:0]    level_reg, level_next;
   logic [2:0]    lives_reg, lives_next;
   logic [PW-1:0] pause_reg, pause_next;
   logic          btn_prev_reg;
   logic [2:0]    screen_reg;
   logic          level_reset_n_reg;

   logic press;
   logic pause_done;

   assign press      = start_button & ~btn_prev_reg;
   assign pause_done = (pause_reg == '0);

   // Overlay code shown for a given state; ARM looks like PLAY to the player.
   function automatic logic [2:0] screen_code(input logic [2:0] st);
      case (st)
         ST_ARM, ST_PLAY: screen_code = 3'd1;
         ST_CLEAR:        screen_code = 3'd2;
         ST_DIED:         screen_code = 3'd3;
         ST_GAME_OVER:    screen_code = 3'd4;
         ST_VICTORY:      screen_code = 3'd5;
         default:         screen_code = 3'd0;
      endcase
   endfunction

   // Next-state, level, lives and pause-counter decisions.
   always_comb begin
      state_next = state_reg;
      level_next = level_reg;
      lives_next = lives_reg;
      pause_next = pause_reg;
      case (state_reg)
         ST_TITLE: begin
            if (press) begin
               state_next = ST_ARM;
               lives_next = LIVES_INIT;
               level_next = 3'd0;
            end
         end
         // One-cycle guard: results still asserted by the level that was
         // just released from reset must not be acted upon.
         ST_ARM: begin
            state_next = ST_PLAY;
         end
         ST_PLAY: begin
            if (level_win) begin
               state_next = ST_CLEAR;
               pause_next = PAUSE_LOAD;
            end else if (level_lose) begin
               state_next = ST_DIED;
               pause_next = PAUSE_LOAD;
`ifdef GAME_FLOW_LIVES_EN
               lives_next = (lives_reg != 3'd0) ? lives_reg - 3'd1 : 3'd0;
`endif
            end
         end
         ST_CLEAR: begin
            if (pause_done) begin
               if (level_reg == LAST_LEVEL) begin
                  state_next = ST_VICTORY;
               end else begin
                  level_next = level_reg + 3'd1;
                  state_next = ST_ARM;
               end
            end else begin
               pause_next = pause_reg - PW'(1);
            end
         end
         ST_DIED: begin
            if (pause_done) begin
`ifdef GAME_FLOW_LIVES_EN
               state_next = (lives_reg == 3'd0) ? ST_GAME_OVER : ST_ARM;
`else
               state_next = ST_ARM;
               level_next = 3'd0;
`endif
            end else begin
               pause_next = pause_reg - PW'(1);
            end
         end
         ST_GAME_OVER, ST_VICTORY: begin
            if (press) begin
               state_next = ST_TITLE;
            end
         end
         default: begin
            state_next = ST_TITLE;
         end
      endcase
   end

   // State, counters and registered outputs; async active-low reset.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         state_reg         <= ST_TITLE;
         level_reg         <= 3'd0;
         lives_reg         <= LIVES_INIT;
         pause_reg         <= '0;
         btn_prev_reg      <= 1'b1;
         screen_reg        <= 3'd0;
         level_reset_n_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         level_reg         <= level_next;
         lives_reg         <= lives_next;
         pause_reg         <= pause_next;
         btn_prev_reg      <= start_button;
         screen_reg        <= screen_code(state_next);
         level_reset_n_reg <= (state_next == ST_ARM) || (state_next == ST_PLAY);
      end
   end

   assign level_sel     = level_reg;
   assign lives         = lives_reg;
   assign screen        = screen_reg;
   assign level_reset_n = level_reset_n_reg;

endmodule
